// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: per-stage enable/flush strobes for load-use, mispredict and data-memory stalls
module hazard_ctrl_unit #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_rs1_id,
    input  logic [4:0]       i_rs2_id,
    input  logic             i_rs1_used_id,
    input  logic             i_rs2_used_id,
    input  logic [4:0]       i_rd_ex,
    input  logic             i_mem_read_ex,
    input  logic             i_mispredict_ex,
    input  logic             i_dmem_req_mem,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_state,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_lu_cnt
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] W_MAX = WW'(TIMEOUT);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t           r_state;
    logic             r_pend;
    logic [WW-1:0]    r_wait;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_lu_cnt;

    logic          w_load_use;
    logic          w_mem_stall;
    logic          w_mp;
    logic          w_run;
    logic          w_rule_mp;
    logic          w_rule_lu;
    logic [WW-1:0] w_wait_nxt;

    assign w_load_use  = i_mem_read_ex && (i_rd_ex != 5'd0) &&
                         ((i_rs1_used_id && (i_rs1_id == i_rd_ex)) ||
                          (i_rs2_used_id && (i_rs2_id == i_rd_ex)));
    assign w_mem_stall = i_dmem_req_mem && !i_dmem_ready;
    assign w_mp        = i_mispredict_ex || r_pend;
    // w_run: not in reset and not frozen by memory, so rules 2-4 may apply
    assign w_run       = !rst && !w_mem_stall;
    assign w_rule_mp   = w_run && w_mp;
    assign w_rule_lu   = w_run && !w_mp && w_load_use;

    assign o_pc_en       = w_run && !w_rule_lu;
    assign o_if_id_en    = w_run && !w_rule_lu;
    assign o_if_id_flush = w_rule_mp;
    assign o_id_ex_en    = w_run;
    assign o_id_ex_flush = w_rule_mp || w_rule_lu;
    assign o_ex_mem_en   = w_run;
    assign o_mem_wb_en   = w_run;

    assign o_state       = r_state;
    assign o_mem_timeout = r_timeout;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;
    assign o_lu_cnt      = r_lu_cnt;

    // only MEM_WAIT stall cycles count toward the timeout; held at TIMEOUT so it never wraps
    assign w_wait_nxt = !w_mem_stall ? '0 :
                        (r_state == MEM_WAIT && r_wait != W_MAX) ? r_wait + WW'(1) : r_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_pend      <= 1'b0;
            r_wait      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            r_state   <= w_mem_stall ? MEM_WAIT : RUN;
            r_pend    <= w_mem_stall && w_mp;
            r_wait    <= w_wait_nxt;
            r_timeout <= r_timeout || (w_wait_nxt == W_MAX);
            if (!o_pc_en && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_rule_mp && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_rule_lu && !(&r_lu_cnt))
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: vector table, directed corner sequences and random run against a reference model
module tb_hazard_ctrl_unit;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam logic [6:0] S_NORM = 7'b1101011;
    localparam logic [6:0] S_LU   = 7'b0001111;
    localparam logic [6:0] S_MP   = 7'b1111111;
    localparam logic [6:0] S_OFF  = 7'b0000000;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       mp;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [6:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_id, rs2_id, rd_ex;
    logic             rs1_used_id, rs2_used_id, mem_read_ex, mispredict_ex, dmem_req_mem, dmem_ready;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic             state_o, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, lu_cnt;

    int n_chk = 0;
    int n_fail = 0;

    int   m_stall, m_flush, m_lu, m_ep;
    logic m_state, m_pend, m_to;
    logic [6:0] cap;

    hazard_ctrl_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
        .i_rs1_used_id(rs1_used_id), .i_rs2_used_id(rs2_used_id),
        .i_rd_ex(rd_ex), .i_mem_read_ex(mem_read_ex), .i_mispredict_ex(mispredict_ex),
        .i_dmem_req_mem(dmem_req_mem), .i_dmem_ready(dmem_ready),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
        .o_id_ex_en(id_ex_en), .o_id_ex_flush(id_ex_flush),
        .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
        .o_state(state_o), .o_mem_timeout(mem_timeout),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_lu_cnt(lu_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t stall(input logic mp);
        in_t v = '0;
        v.req = 1'b1;
        v.mp  = mp;
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_lu = 0; m_ep = 0;
        m_state = 1'b0; m_pend = 1'b0; m_to = 1'b0;
    endtask

    // one clock: drive, compare against the model mid-cycle, clock it, advance the model
    task automatic run_cycle(input in_t v);
        logic lu, st, mpx;
        logic [6:0] exp;
        rst = v.rst; rs1_id = v.rs1; rs2_id = v.rs2; rs1_used_id = v.u1; rs2_used_id = v.u2;
        rd_ex = v.rd; mem_read_ex = v.mr; mispredict_ex = v.mp; dmem_req_mem = v.req; dmem_ready = v.rdy;
        lu  = v.mr && v.rd != 5'd0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        st  = v.req && !v.rdy;
        mpx = v.mp || m_pend;
        exp = (v.rst || st) ? S_OFF : mpx ? S_MP : lu ? S_LU : S_NORM;
        #2;
        cap = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
        chk("strobes", 32'(cap), 32'(exp));
        chk("state_o", 32'(state_o), 32'(m_state));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("lu_cnt", 32'(lu_cnt), 32'(m_lu));
        @(posedge clk);
        #1;
        if (v.rst) model_reset();
        else begin
            if (!exp[6]) m_stall = sat(m_stall);
            if (!st && mpx) m_flush = sat(m_flush);
            if (!st && !mpx && lu) m_lu = sat(m_lu);
            m_state = st;
            m_pend  = st && mpx;
            m_ep    = st ? m_ep + 1 : 0;
            if (m_ep - 1 >= TIMEOUT) m_to = 1'b1;
        end
    endtask

    task automatic do_reset();
        in_t v = '0;
        v.rst = 1'b1;
        run_cycle(v);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cnt", 32'({stall_cnt, flush_cnt, lu_cnt}), 32'd0);
    endtask

    initial begin
        vec_t tbl[9];
        in_t v;
        rst = 1'b1; rs1_id = '0; rs2_id = '0; rs1_used_id = 1'b0; rs2_used_id = 1'b0; rd_ex = '0;
        mem_read_ex = 1'b0; mispredict_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        // fields: rst rs1 rs2 u1 u2 rd mr mp req rdy | expected {pc,ifen,iff,iden,idf,exen,wben}
        tbl[0] = '{'{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, S_NORM};
        tbl[1] = '{'{1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0}, S_LU};
        tbl[2] = '{'{1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}, S_NORM};
        tbl[3] = '{'{1'b0, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0}, S_NORM};
        tbl[4] = '{'{1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0}, S_NORM};
        tbl[5] = '{'{1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0}, S_MP};
        tbl[6] = '{'{1'b0, 5'd2, 5'd4, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0}, S_MP};
        tbl[7] = '{'{1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1}, S_LU};
        tbl[8] = '{'{1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1}, S_NORM};
        for (int i = 0; i < 9; i++) begin
            run_cycle(tbl[i].i);
            chk($sformatf("vec%0d", i), 32'(cap), 32'(tbl[i].exp));
        end
        chk("tbl_lu_cnt", 32'(lu_cnt), 32'd2);
        chk("tbl_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("tbl_stall_cnt", 32'(stall_cnt), 32'd2);

        // three-cycle memory stall
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(stall(1'b0));
            chk("mstall_frozen", 32'(cap), 32'(S_OFF));
            chk("mstall_state", 32'(state_o), 32'd1);
        end
        v = stall(1'b0); v.rdy = 1'b1;
        run_cycle(v);
        chk("mstall_release", 32'(cap), 32'(S_NORM));
        chk("mstall_state_run", 32'(state_o), 32'd0);
        chk("mstall_cnt", 32'(stall_cnt), 32'd3);

        // mispredict during stall (two pulses) is applied once in the release cycle
        do_reset();
        run_cycle(stall(1'b0));
        run_cycle(stall(1'b1));
        chk("pend_no_flush1", 32'(cap), 32'(S_OFF));
        run_cycle(stall(1'b1));
        chk("pend_no_flush2", 32'(cap), 32'(S_OFF));
        v = stall(1'b0); v.rdy = 1'b1;
        run_cycle(v);
        chk("pend_release_flush", 32'(cap), 32'(S_MP));
        run_cycle(idle());
        chk("pend_cleared", 32'(cap), 32'(S_NORM));
        chk("pend_flush_cnt", 32'(flush_cnt), 32'd1);

        // mispredict coinciding with the ready cycle
        do_reset();
        run_cycle(stall(1'b0));
        v = stall(1'b1); v.rdy = 1'b1;
        run_cycle(v);
        chk("rdy_mp_flush", 32'(cap), 32'(S_MP));
        run_cycle(idle());
        chk("rdy_mp_once", 32'(cap), 32'(S_NORM));
        chk("rdy_mp_cnt", 32'(flush_cnt), 32'd1);

        // timeout with ready held low for six cycles
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(stall(1'b0));
        chk("to_early", 32'(mem_timeout), 32'd0);
        for (int i = 0; i < 3; i++) run_cycle(stall(1'b0));
        chk("to_set", 32'(mem_timeout), 32'd1);
        run_cycle(idle());
        run_cycle(idle());
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        do_reset();
        chk("to_cleared", 32'(mem_timeout), 32'd0);

        // reset in the middle of a stall with a pending flush
        run_cycle(stall(1'b0));
        run_cycle(stall(1'b1));
        v = stall(1'b0); v.rst = 1'b1;
        run_cycle(v);
        chk("rstmid_off", 32'(cap), 32'(S_OFF));
        chk("rstmid_state", 32'(state_o), 32'd0);
        chk("rstmid_cnt", 32'({stall_cnt, flush_cnt, lu_cnt}), 32'd0);
        run_cycle(idle());
        chk("rstmid_no_flush", 32'(cap), 32'(S_NORM));

        // random traffic, long enough to saturate the narrow counters
        for (int n = 0; n < 1500; n++) begin
            v.rst = ($urandom_range(0, 99) == 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 3));
            v.mr  = 1'($urandom_range(0, 1));
            v.mp  = ($urandom_range(0, 5) == 0);
            v.req = ($urandom_range(0, 2) != 0);
            v.rdy = ($urandom_range(0, 2) == 0);
            run_cycle(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
